// File: rtl/cpu_defs.sv
// Shared definitions for the pipeline hazard controller: operand-use encoding,
// MDU state encoding, default MDU latencies and the per-source hazard compare.
package cpu_defs;

    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_e;

    // A source stalls when a younger producer will not have its value ready by the time D needs it.
    function automatic logic src_hazard(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] e_wa,
        input logic [1:0] e_tnew,
        input logic [4:0] m_wa,
        input logic [1:0] m_tnew
    );
        logic used;
        used = (tuse != TUSE_NONE) && (src != 5'd0);
        return used && (((src == e_wa) && (tuse < e_tnew)) ||
                        ((src == m_wa) && (tuse < m_tnew)));
    endfunction

endpackage

// File: rtl/mdu_busy_timer.sv
// Busy window of the multi-cycle mult/div unit: a start in cycle t keeps busy
// high for exactly cycles t+1..t+N, where N depends on the operation.
module mdu_busy_timer
    import cpu_defs::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [CW-1:0] MULT_LEN = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LEN  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] ONE      = CW'(1);

    mdu_state_e     r_state;
    logic [CW-1:0]  r_cnt;
    logic           r_busy;

    // MDU state, remaining-cycle counter and registered busy flag; a new start always reloads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= MDU_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else if (start) begin
            r_state <= MDU_BUSY;
            r_cnt   <= is_div ? DIV_LEN : MULT_LEN;
            r_busy  <= 1'b1;
        end else begin
            case (r_state)
                MDU_BUSY: begin
                    if (r_cnt <= ONE) begin
                        r_state <= MDU_IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= MDU_BUSY;
                        r_cnt   <= r_cnt - ONE;
                        r_busy  <= 1'b1;
                    end
                end
                MDU_IDLE: begin
                    r_state <= MDU_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= MDU_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall controller for the 5-stage pipeline: register and MDU hazard
// detection driving PC/F-D hold and D/E bubble, plus a saturating stall counter.
module pipe_hazard_ctrl
    import cpu_defs::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       d_rs,
    input  logic [4:0]       d_rt,
    input  logic [1:0]       d_tuse_rs,
    input  logic [1:0]       d_tuse_rt,
    input  logic             d_md_use,
    input  logic [4:0]       e_wa,
    input  logic [1:0]       e_tnew,
    input  logic [4:0]       m_wa,
    input  logic [1:0]       m_tnew,
    input  logic             e_md_start,
    input  logic             e_md_is_div,
    output logic             pc_en,
    output logic             fd_en,
    output logic             de_flush,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             w_hz_rs;
    logic             w_hz_rt;
    logic             w_hz_md;
    logic             w_stall;
    logic             w_md_busy;
    logic [CNT_W-1:0] r_stall_cnt;

    mdu_busy_timer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_mdu_timer (
        .clk    (clk),
        .reset  (reset),
        .start  (e_md_start),
        .is_div (e_md_is_div),
        .busy   (w_md_busy)
    );

    // Same-cycle hazard detection; the MDU result is not ready while starting or busy.
    always_comb begin
        w_hz_rs = src_hazard(d_rs, d_tuse_rs, e_wa, e_tnew, m_wa, m_tnew);
        w_hz_rt = src_hazard(d_rt, d_tuse_rt, e_wa, e_tnew, m_wa, m_tnew);
        w_hz_md = d_md_use & (e_md_start | w_md_busy);
        w_stall = w_hz_rs | w_hz_rt | w_hz_md;
    end

    // Stall-cycle counter, held at all-ones once full.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + CNT_ONE;
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    assign pc_en     = ~w_stall;
    assign fd_en     = ~w_stall;
    assign de_flush  = w_stall;
    assign md_busy   = w_md_busy;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage MIPS pipeline (F/D/E/M/W).
- Compares the D-stage source registers and Tuse against the E/M-stage destinations and Tnew, and sequences the multi-cycle mult/div unit (MDU) busy window.
- Drives the hold/bubble controls of the PC and the F/D and D/E pipeline registers.
- Keeps a saturating stall-cycle counter for performance checks.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu start.
- DIV_CYCLES, 10, busy cycles after a div/divu start.
- CNT_W, 32, width of the stall counter.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-low reset; reset==0 clears all state immediately.
- d_rs  in  5  D-stage rs address.
- d_rt  in  5  D-stage rt address.
- d_tuse_rs  in  2  D-stage Tuse for rs; 3 = not used.
- d_tuse_rt  in  2  D-stage Tuse for rt; 3 = not used.
- d_md_use  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo.
- e_wa  in  5  E-stage destination register.
- e_tnew  in  2  E-stage Tnew (0..2).
- m_wa  in  5  M-stage destination register.
- m_tnew  in  2  M-stage Tnew (0..1).
- e_md_start  in  1  E instruction starts the MDU this cycle.
- e_md_is_div  in  1  qualifies e_md_start: 1 = div, 0 = mult.
- pc_en  out  1  PC write enable.
- fd_en  out  1  F/D register enable (0 = hold).
- de_flush  out  1  D/E register stall input; inserts a bubble (register loads 0).
- md_busy  out  1  MDU busy.
- stall_cnt  out  CNT_W  stall cycles since reset.

Behaviour:
- Reset (reset==0, asynchronous): md_busy=0, internal busy counter=0, stall_cnt=0. Combinational outputs follow from the cleared state: pc_en=1, fd_en=1, de_flush=0 when no hazard is present.
- Register hazard, combinational:
  - hz_rs = (d_rs!=0) & ((d_rs==e_wa & d_tuse_rs<e_tnew) | (d_rs==m_wa & d_tuse_rs<m_tnew)).
  - hz_rt is the same with d_rt / d_tuse_rt.
  - Writes to $0 never cause a hazard.
  - Tuse=3 never stalls.
- MDU hazard: hz_md = d_md_use & (e_md_start | md_busy).
- stall = hz_rs | hz_rt | hz_md, combinational, same cycle.
  - pc_en = fd_en = ~stall.
  - de_flush = stall.
- MDU FSM, states IDLE and BUSY, with a down-counter cnt of width clog2(DIV_CYCLES+1):
  - IDLE + e_md_start: go to BUSY; cnt = e_md_is_div ? DIV_CYCLES : MULT_CYCLES.
  - BUSY: cnt decrements each cycle; at cnt==1, next state is IDLE.
  - md_busy = (state==BUSY), registered.
  - A start in cycle t gives md_busy high for exactly the N cycles t+1..t+N.
  - A start while BUSY (illegal but defined) reloads cnt with the new length and stays BUSY.
- stall_cnt increments at each clock edge where stall==1. It saturates at all-ones and never wraps.
- Reset asserted mid-busy aborts the operation immediately; the next cycle is IDLE.
- Simultaneous rs and rt hazards count as one stall cycle.
- No latency on the control outputs: all are valid in the same cycle as the inputs.

Decomposition:
- Shared package, cpu_defs:
  - TUSE_NONE=2'd3.
  - MDU state encoding IDLE=1'b0, BUSY=1'b1.
  - Default MULT_CYCLES and DIV_CYCLES constants.
- One natural sub-module, mdu_busy_timer: the FSM plus down-counter, with ports clk, reset, start, is_div, busy.
- The hazard compare and stall_cnt stay in the top module.

Test Plan:
- Load-use: d_rs=8, d_tuse_rs=0, e_wa=8, e_tnew=2 -> stall=1 for 1 cycle; then M-stage m_wa=8, m_tnew=1 -> stall=1 for a 2nd cycle; stall_cnt=2.
- $0 and no-use: d_rs=0 with e_wa=0, e_tnew=2 -> no stall; d_tuse_rt=3 matching e_wa -> no stall.
- Div window: e_md_start=1, e_md_is_div=1 at cycle t -> md_busy high exactly cycles t+1..t+10. A d_md_use instruction held in D stalls from t through t+10 (11 cycles).
- Mult window: start with is_div=0 -> md_busy high for exactly 5 cycles. An instruction with d_md_use=0 is never stalled.
- Reset mid-op: drop reset low at busy cycle 4 of a div -> md_busy=0 and stall_cnt=0 asynchronously. After release, d_md_use gives no stall.
- Saturation: CNT_W=4, hold a hazard for 20 cycles -> stall_cnt stays at 15.
